// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, nibble width and the double-dabble add-3 threshold.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int             NIB_W       = 4;
    localparam logic [NIB_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Combinational double-dabble correction for one BCD nibble: add 3 when >= 5.
module bcd_nibble_adj
    import bin2bcd_pkg::*;
(
    input  logic [NIB_W-1:0] din,
    output logic [NIB_W-1:0] dout
);

    // Input is always <= 9, so the 4-bit sum never wraps.
    assign dout = (din >= ADD3_THRESH) ? din + NIB_W'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [NIB_W*DIGITS-1:0]   bcd,
    output logic                      overflow,
    output logic [DIGITS-1:0]         blank
);

    localparam int BCD_W = NIB_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state, state_next;
    logic [SR_W-1:0]    sr, sr_next, sr_adj, sr_shift;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               ovf_acc, ovf_acc_next, ovf_final;
    logic               finish;
    logic [BCD_W-1:0]   bcd_field;

    // Binary part passes through; each BCD nibble gets its add-3 correction.
    assign sr_adj[BIN_W-1:0] = sr[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .din  (sr[BIN_W + NIB_W*g +: NIB_W]),
            .dout (sr_adj[BIN_W + NIB_W*g +: NIB_W])
        );
    end

    assign sr_shift  = {sr_adj[SR_W-2:0], 1'b0};
    assign ovf_final = ovf_acc | sr_adj[SR_W-1];
    assign bcd_field = sr_shift[SR_W-1:BIN_W];
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else begin
            state   <= state_next;
            sr      <= sr_next;
            cnt     <= cnt_next;
            ovf_acc <= ovf_acc_next;
        end
    end

    always_comb begin
        state_next   = state;
        sr_next      = sr;
        cnt_next     = cnt;
        ovf_acc_next = ovf_acc;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sr_next      = {{BCD_W{1'b0}}, bin};
                    cnt_next     = CNT_W'(BIN_W);
                    ovf_acc_next = 1'b0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                sr_next      = sr_shift;
                ovf_acc_next = ovf_final;
                cnt_next     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Results update together, only on the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                bcd      <= bcd_field;
                overflow <= ovf_final;
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] mask;
    logic              higher_zero;

    // Digit 0 is never blanked so a zero value still shows "0".
    always_comb begin
        mask        = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero & (bcd_field[i*NIB_W +: NIB_W] == '0);
            mask[i]     = higher_zero & ~ovf_final;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else if (finish) begin
            blank <= mask;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (4-digit and 3-digit instances).
module tb_bin2bcd_seq;

`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        start4 = 1'b0;
    logic [11:0] bin4   = '0;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;

    logic        start3 = 1'b0;
    logic [11:0] bin3   = '0;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic [2:0]  blank3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4), .blank(blank4)
    );

    bin2bcd_seq #(.BIN_W(12), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3), .blank(blank3)
    );

    // Pulses start for one edge, then counts edges until done is seen.
    task automatic run_conv(input bit sel3, input logic [11:0] v,
                            output int edges, output int busy_cycles);
        @(negedge clk);
        if (sel3) begin bin3 = v; start3 = 1'b1; end
        else      begin bin4 = v; start4 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start3 = 1'b0;
        start4 = 1'b0;
        edges = 1;
        busy_cycles = 0;
        while (((sel3 ? done3 : done4) == 1'b0) && edges < 40) begin
            if (sel3 ? busy3 : busy4) busy_cycles++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({busy4, done4, ovf4} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags4 actual=%b expected=000", {busy4, done4, ovf4}); end
        total++; if (bcd4 !== 16'h0000) begin bad++; $display("[TB] FAIL reset_bcd4 actual=%h expected=0000", bcd4); end
        total++; if (blank4 !== 4'b0000) begin bad++; $display("[TB] FAIL reset_blank4 actual=%b expected=0000", blank4); end
        total++; if ({busy3, done3, ovf3, bcd3, blank3} !== 18'd0) begin bad++; $display("[TB] FAIL reset_dut3 actual=%h expected=0", {busy3, done3, ovf3, bcd3, blank3}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max();
        int e, b;
        run_conv(1'b0, 12'd4095, e, b);
        total++; if (e !== 13) begin bad++; $display("[TB] FAIL max_latency actual=%0d expected=13", e); end
        total++; if (b !== 12) begin bad++; $display("[TB] FAIL max_busy_cycles actual=%0d expected=12", b); end
        total++; if (bcd4 !== 16'h4095) begin bad++; $display("[TB] FAIL max_bcd actual=%h expected=4095", bcd4); end
        total++; if (ovf4 !== 1'b0) begin bad++; $display("[TB] FAIL max_ovf actual=%b expected=0", ovf4); end
        total++; if (blank4 !== 4'b0000) begin bad++; $display("[TB] FAIL max_blank actual=%b expected=0000", blank4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL max_busy_at_done actual=%b expected=0", busy4); end
        @(posedge clk);
        @(negedge clk);
        total++; if (done4 !== 1'b0) begin bad++; $display("[TB] FAIL max_done_pulse actual=%b expected=0", done4); end
        total++; if (bcd4 !== 16'h4095) begin bad++; $display("[TB] FAIL max_bcd_hold actual=%h expected=4095", bcd4); end
    endtask

    task automatic test_zero();
        int e, b;
        logic [3:0] exp_blank;
        exp_blank = BLANK_ON ? 4'b1110 : 4'b0000;
        run_conv(1'b0, 12'd0, e, b);
        total++; if (e !== 13) begin bad++; $display("[TB] FAIL zero_latency actual=%0d expected=13", e); end
        total++; if (bcd4 !== 16'h0000) begin bad++; $display("[TB] FAIL zero_bcd actual=%h expected=0000", bcd4); end
        total++; if (blank4 !== exp_blank) begin bad++; $display("[TB] FAIL zero_blank actual=%b expected=%b", blank4, exp_blank); end
    endtask

    task automatic test_overflow3();
        int e, b;
        run_conv(1'b1, 12'd1000, e, b);
        total++; if (e !== 13) begin bad++; $display("[TB] FAIL ovf_latency actual=%0d expected=13", e); end
        total++; if (bcd3 !== 12'h000) begin bad++; $display("[TB] FAIL ovf_bcd actual=%h expected=000", bcd3); end
        total++; if (ovf3 !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag actual=%b expected=1", ovf3); end
        total++; if (blank3 !== 3'b000) begin bad++; $display("[TB] FAIL ovf_blank actual=%b expected=000", blank3); end
        run_conv(1'b1, 12'd999, e, b);
        total++; if (bcd3 !== 12'h999) begin bad++; $display("[TB] FAIL ovf999_bcd actual=%h expected=999", bcd3); end
        total++; if (ovf3 !== 1'b0) begin bad++; $display("[TB] FAIL ovf999_flag actual=%b expected=0", ovf3); end
        total++; if (blank3 !== 3'b000) begin bad++; $display("[TB] FAIL ovf999_blank actual=%b expected=000", blank3); end
    endtask

    task automatic test_ignore_busy();
        int e;
        logic [3:0] exp_blank;
        exp_blank = BLANK_ON ? 4'b1100 : 4'b0000;
        @(negedge clk);
        bin4 = 12'd57; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        e = 1;
        repeat (3) begin @(posedge clk); e++; @(negedge clk); end
        bin4 = 12'd321; start4 = 1'b1;
        @(posedge clk); e++;
        @(negedge clk);
        start4 = 1'b0;
        while (done4 == 1'b0 && e < 40) begin @(posedge clk); e++; @(negedge clk); end
        total++; if (e !== 13) begin bad++; $display("[TB] FAIL ignore_latency actual=%0d expected=13", e); end
        total++; if (bcd4 !== 16'h0057) begin bad++; $display("[TB] FAIL ignore_bcd actual=%h expected=0057", bcd4); end
        total++; if (blank4 !== exp_blank) begin bad++; $display("[TB] FAIL ignore_blank actual=%b expected=%b", blank4, exp_blank); end
        @(posedge clk);
        @(negedge clk);
        total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL ignore_no_restart actual=%b expected=0", busy4); end
    endtask

    task automatic test_back_to_back();
        int e;
        logic [3:0] exp_blank;
        exp_blank = BLANK_ON ? 4'b1000 : 4'b0000;
        @(negedge clk);
        bin4 = 12'd500; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bin4 = 12'd123;
        e = 1;
        while (done4 == 1'b0 && e < 40) begin @(posedge clk); e++; @(negedge clk); end
        total++; if (e !== 13) begin bad++; $display("[TB] FAIL b2b_first_latency actual=%0d expected=13", e); end
        total++; if (bcd4 !== 16'h0500) begin bad++; $display("[TB] FAIL b2b_first_bcd actual=%h expected=0500", bcd4); end
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        e = 1;
        total++; if (busy4 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept actual=%b expected=1", busy4); end
        repeat (5) begin @(posedge clk); e++; @(negedge clk); end
        total++; if (bcd4 !== 16'h0500) begin bad++; $display("[TB] FAIL b2b_hold actual=%h expected=0500", bcd4); end
        while (done4 == 1'b0 && e < 40) begin @(posedge clk); e++; @(negedge clk); end
        total++; if (e !== 13) begin bad++; $display("[TB] FAIL b2b_second_latency actual=%0d expected=13", e); end
        total++; if (bcd4 !== 16'h0123) begin bad++; $display("[TB] FAIL b2b_second_bcd actual=%h expected=0123", bcd4); end
        total++; if (blank4 !== exp_blank) begin bad++; $display("[TB] FAIL b2b_blank actual=%b expected=%b", blank4, exp_blank); end
    endtask

    task automatic test_reset_mid();
        int e, b;
        bit seen_done;
        @(negedge clk);
        bin4 = 12'd2048; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy actual=%b expected=0", busy4); end
        total++; if (bcd4 !== 16'h0000) begin bad++; $display("[TB] FAIL rstmid_bcd actual=%h expected=0000", bcd4); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (20) begin @(posedge clk); @(negedge clk); seen_done |= done4; end
        total++; if (seen_done !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_done actual=%b expected=0", seen_done); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_idle actual=%b expected=0", busy4); end
        run_conv(1'b0, 12'd2048, e, b);
        total++; if (e !== 13) begin bad++; $display("[TB] FAIL rstmid_latency actual=%0d expected=13", e); end
        total++; if (bcd4 !== 16'h2048) begin bad++; $display("[TB] FAIL rstmid_bcd_after actual=%h expected=2048", bcd4); end
        total++; if (blank4 !== 4'b0000) begin bad++; $display("[TB] FAIL rstmid_blank actual=%b expected=0000", blank4); end
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero();
        test_overflow3();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
